// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/forward_sel.sv
// Execute-stage operand forward select for one source register; M beats W.
module forward_sel #(
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs,
    input  logic [REG_ADDR_WIDTH-1:0] rd_m,
    input  logic                      reg_write_m,
    input  logic [REG_ADDR_WIDTH-1:0] rd_w,
    input  logic                      reg_write_w,
    output logic [1:0]                fwd_sel_c
);
    import hazard_pkg::*;

    always_comb begin
        fwd_sel_c = FWD_RF;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
            fwd_sel_c = FWD_M;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
            fwd_sel_c = FWD_W;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the five-stage pipe: load-use bubbles,
// multi-cycle multiply stalls, data-cache miss freezes and redirect squashes.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned MUL_LATENCY    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_d,
    input  logic [REG_ADDR_WIDTH-1:0] RS1_d,
    input  logic [REG_ADDR_WIDTH-1:0] RS2_d,
    input  logic                      valid_e,
    input  logic [REG_ADDR_WIDTH-1:0] RS1_e,
    input  logic [REG_ADDR_WIDTH-1:0] RS2_e,
    input  logic [REG_ADDR_WIDTH-1:0] Rd_e,
    input  logic                      RegWrite_e,
    input  logic [1:0]                ResultSrc_e,
    input  logic                      mul_sel_e,
    input  logic                      pc_redirect_e,
    input  logic                      valid_m,
    input  logic [REG_ADDR_WIDTH-1:0] Rd_m,
    input  logic                      RegWrite_m,
    input  logic                      dcache_miss_m,
    input  logic                      dcache_ready_m,
    input  logic [REG_ADDR_WIDTH-1:0] Rd_w,
    input  logic                      RegWrite_w,
    output logic                      en_f,
    output logic                      en_d,
    output logic                      en_e,
    output logic                      en_m,
    output logic                      en_w,
    output logic                      flush_d_n,
    output logic                      flush_e_n,
    output logic                      flush_m_n,
    output logic                      flush_w_n,
    output logic [1:0]                fwd_a_e,
    output logic [1:0]                fwd_b_e,
    output logic                      mul_busy
);
    import hazard_pkg::*;

    localparam int unsigned CNT_W = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;

    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use_c;
    logic             redirect_c;
    logic             resolve_c;
    logic [1:0]       sel_a_c, sel_b_c;

    forward_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
        .rs          (RS1_e),
        .rd_m        (Rd_m),
        .reg_write_m (RegWrite_m),
        .rd_w        (Rd_w),
        .reg_write_w (RegWrite_w),
        .fwd_sel_c   (sel_a_c)
    );

    forward_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
        .rs          (RS2_e),
        .rd_m        (Rd_m),
        .reg_write_m (RegWrite_m),
        .rd_w        (Rd_w),
        .reg_write_w (RegWrite_w),
        .fwd_sel_c   (sel_b_c)
    );

    assign fwd_a_e = rst_n ? sel_a_c : FWD_RF;
    assign fwd_b_e = rst_n ? sel_b_c : FWD_RF;

    assign load_use_c = valid_e && RegWrite_e && (ResultSrc_e == RESULT_SRC_LOAD)
                        && (Rd_e != '0) && valid_d && ((Rd_e == RS1_d) || (Rd_e == RS2_d));
    assign redirect_c = valid_e && pc_redirect_e;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // resolve_c marks a cycle where E advances, so redirect/load-use may act
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        resolve_c = 1'b0;
        en_f      = 1'b1;
        en_d      = 1'b1;
        en_e      = 1'b1;
        en_m      = 1'b1;
        en_w      = 1'b1;
        flush_d_n = 1'b1;
        flush_e_n = 1'b1;
        flush_m_n = 1'b1;
        flush_w_n = 1'b1;
        mul_busy  = 1'b0;

        if (!rst_n) begin
            flush_d_n = 1'b0;
            flush_e_n = 1'b0;
            flush_m_n = 1'b0;
            flush_w_n = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_m && dcache_miss_m) begin
                        {en_f, en_d, en_e, en_m} = 4'b0000;
                        flush_w_n = 1'b0;
                        state_d   = MEM_WAIT;
                    end else if (valid_e && mul_sel_e) begin
                        {en_f, en_d, en_e} = 3'b000;
                        flush_m_n = 1'b0;
                        cnt_d     = CNT_W'(MUL_LATENCY - 2);
                        state_d   = MUL_BUSY;
                    end else begin
                        resolve_c = 1'b1;
                    end
                end
                MUL_BUSY: begin
                    mul_busy = 1'b1;
                    if (cnt_q != '0) begin
                        {en_f, en_d, en_e} = 3'b000;
                        flush_m_n = 1'b0;
                        cnt_d     = cnt_q - CNT_W'(1);
                    end else begin
                        state_d   = IDLE;
                        resolve_c = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (dcache_ready_m) begin
                        state_d   = IDLE;
                        resolve_c = 1'b1;
                    end else begin
                        {en_f, en_d, en_e, en_m} = 4'b0000;
                        flush_w_n = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (resolve_c) begin
                if (redirect_c) begin
                    flush_d_n = 1'b0;
                    flush_e_n = 1'b0;
                end else if (load_use_c) begin
                    en_f      = 1'b0;
                    en_d      = 1'b0;
                    flush_e_n = 1'b0;
                end
            end
        end
    end

endmodule
